// File: rtl/adder_unit.sv
// adder_unit: ripple-carry adder with combinational sum and a registered copy
module adder_unit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic [WIDTH-1:0] S_q,
  output logic             cout_q
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign cout = c[WIDTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      S_q    <= S;
      cout_q <= cout;
    end
  end
endmodule

// File: tb/tb_adder_unit.sv
// tb_adder_unit: directed and randomized checks of adder_unit against arithmetic A+B+cin
module tb_adder_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a2, b2, s2, s2_q;
  logic       ci2, co2, co2_q;
  logic [7:0] a8, b8, s8, s8_q;
  logic       ci8, co8, co8_q;
  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_unit #(.WIDTH(2)) dut (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .cin(ci2),
    .S(s2), .cout(co2), .S_q(s2_q), .cout_q(co2_q)
  );

  adder_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .cin(ci8),
    .S(s8), .cout(co8), .S_q(s8_q), .cout_q(co8_q)
  );

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply2(input string tag, input int a, input int b, input int ci);
    logic [8:0] e;
    e = 9'(a + b + ci);
    @(negedge clk);
    a2 = 2'(a); b2 = 2'(b); ci2 = 1'(ci);
    #1 chk({tag, " comb"}, {6'b0, co2, s2}, e);
    @(posedge clk);
    #1 chk({tag, " reg"}, {6'b0, co2_q, s2_q}, e);
  endtask

  task automatic apply8(input int a, input int b, input int ci);
    logic [8:0] e;
    e = 9'(a + b + ci);
    @(negedge clk);
    a8 = 8'(a); b8 = 8'(b); ci8 = 1'(ci);
    #1 chk("w8 comb", {co8, s8}, e);
    @(posedge clk);
    #1 chk("w8 reg", {co8_q, s8_q}, e);
  endtask

  initial begin
    rst = 1'b1;
    a2 = 2'b10; b2 = 2'b11; ci2 = 1'b1;
    a8 = 8'd0; b8 = 8'd0; ci8 = 1'b0;
    #12;
    chk("reset S_q/cout_q", {6'b0, co2_q, s2_q}, 9'd0);
    chk("reset w8 regs", {co8_q, s8_q}, 9'd0);
    chk("comb valid in reset", {6'b0, co2, s2}, 9'd6);
    @(posedge clk);
    #1 chk("reset holds across edge", {6'b0, co2_q, s2_q}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("first load after reset", {6'b0, co2_q, s2_q}, 9'd6);
    apply2("t1", 2, 3, 1);
    apply2("t2a", 1, 3, 1);
    apply2("t2b", 1, 0, 1);
    apply2("t2c", 2, 0, 1);
    apply2("t2d", 2, 3, 1);
    for (int v = 0; v < 32; v++) apply2("sweep", v[4:3], v[2:1], v[0]);
    apply2("all ones", 3, 3, 1);
    apply2("all zeros", 0, 0, 0);
    apply2("full ripple", 3, 0, 1);
    for (int k = 0; k < 10; k++)
      apply2("rand2", $urandom_range(3), $urandom_range(3), $urandom_range(1));
    apply2("pre mid reset", 1, 1, 0);
    #2 rst = 1'b1;
    #1 chk("mid reset regs clear", {6'b0, co2_q, s2_q}, 9'd0);
    chk("mid reset comb tracks", {6'b0, co2, s2}, 9'd2);
    a2 = 2'b11; b2 = 2'b01; ci2 = 1'b0;
    #1 chk("comb tracks in reset", {6'b0, co2, s2}, 9'd4);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("reload after reset", {6'b0, co2_q, s2_q}, 9'd4);
    apply8(255, 255, 1);
    apply8(0, 0, 0);
    apply8(255, 0, 1);
    for (int k = 0; k < 40; k++)
      apply8($urandom_range(255), $urandom_range(255), $urandom_range(1));
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
